// File: rtl/load_store_unit.sv
// load_store_unit: RV32I memory-access stage with a single-outstanding req/gnt/rvalid port.
// Optional build macro MISALIGN_TRAP_EN: misaligned ops complete without a memory access, flagging misalign_o.
`default_nettype none

module load_store_unit #(
    parameter int RSP_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        is_store_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_wmask_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_data_o,
    output logic        err_o,
    output logic        misalign_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;
    localparam int CNT_W = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;

    logic [1:0]       state_q, state_d;
    logic             we_q, we_d;
    logic [2:0]       f3_q, f3_d;
    logic [31:0]      addr_q, addr_d;
    logic [3:0]       wmask_q, wmask_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;
    logic             mis_q, mis_d;

    logic        w_illegal, w_trap, w_timeout;
    logic [3:0]  w_wmask;
    logic [31:0] w_wdata, w_ext;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_illegal = is_store_i ? (funct3_i >= 3'd3)
                                  : ((funct3_i == 3'd3) || (funct3_i[2:1] == 2'b11));
`ifdef MISALIGN_TRAP_EN
    assign w_trap = ~w_illegal &
                    (((funct3_i[1:0] == 2'b01) & addr_i[0]) |
                     ((funct3_i[1:0] == 2'b10) & (addr_i[1:0] != 2'b00)));
`else
    assign w_trap = 1'b0;
`endif
    assign w_timeout = (RSP_TIMEOUT != 0) && (cnt_q == CNT_W'(RSP_TIMEOUT - 1));

    // Store lanes: low address bits beyond the access size are ignored here.
    always_comb begin
        w_wmask = 4'b0000;
        w_wdata = 32'd0;
        if (is_store_i) begin
            case (funct3_i)
                3'd0: begin
                    w_wmask = 4'b0001 << addr_i[1:0];
                    w_wdata = {4{wdata_i[7:0]}};
                end
                3'd1: begin
                    w_wmask = 4'b0011 << {addr_i[1], 1'b0};
                    w_wdata = {2{wdata_i[15:0]}};
                end
                3'd2: begin
                    w_wmask = 4'b1111;
                    w_wdata = wdata_i;
                end
                default: ;
            endcase
        end
    end

    assign w_byte = mem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
    assign w_half = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

    always_comb begin
        case (f3_q)
            3'd0:    w_ext = {{24{w_byte[7]}}, w_byte};
            3'd4:    w_ext = {24'd0, w_byte};
            3'd1:    w_ext = {{16{w_half[15]}}, w_half};
            3'd5:    w_ext = {16'd0, w_half};
            default: w_ext = mem_rdata_i;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 32'd0;
            wmask_q <= 4'd0;
            wdata_q <= 32'd0;
            cnt_q   <= '0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wmask_q <= wmask_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            mis_q   <= mis_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_valid_i) state_d = (w_illegal | w_trap) ? S_RESP : S_REQ;
            S_REQ:   if (mem_gnt_i) state_d = we_q ? S_RESP : S_WAIT;
            S_WAIT:  if (mem_rvalid_i | w_timeout) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Result flags and data are cleared only on the next accept, so they stay readable after RESP.
    always_comb begin
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wmask_d = wmask_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mis_d   = mis_q;
        if (state_q == S_IDLE && req_valid_i) begin
            we_d    = is_store_i;
            f3_d    = funct3_i;
            addr_d  = addr_i;
            wmask_d = w_wmask;
            wdata_d = w_wdata;
            cnt_d   = '0;
            rdata_d = 32'd0;
            err_d   = w_illegal;
            mis_d   = w_trap;
        end else if (state_q == S_WAIT) begin
            cnt_d = cnt_q + 1'b1;
            if (mem_rvalid_i) begin
                rdata_d = w_ext;
            end else if (w_timeout) begin
                err_d = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready_o = (state_q == S_IDLE);
        mem_req_o   = (state_q == S_REQ);
        rsp_valid_o = (state_q == S_RESP);
    end

    assign mem_we_o    = we_q;
    assign mem_addr_o  = {addr_q[31:2], 2'b00};
    assign mem_wmask_o = wmask_q;
    assign mem_wdata_o = wdata_q;
    assign rsp_data_o  = rdata_q;
    assign err_o       = err_q;
    assign misalign_o  = mis_q;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized and directed checks of load_store_unit against a byte-level reference model.
`default_nettype none

module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, is_store;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;
    logic        rsp_valid, err, misalign;
    logic [31:0] rsp_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.RSP_TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .is_store_i(is_store), .funct3_i(funct3), .addr_i(addr), .wdata_i(wdata),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wmask_o(mem_wmask), .mem_wdata_o(mem_wdata),
        .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
        .err_o(err), .misalign_o(misalign)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One transaction: gd = extra REQ cycles before gnt, rd = WAIT cycle index carrying rvalid.
    task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int gd, input int rd,
                         input logic [31:0] rdat);
        int size, eoff;
        bit legal, mis, trap, access, tmo;
        logic [3:0]  emask;
        logic [31:0] ewd, ext, edata;
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        mis   = legal && ((a % size) != 0);
`ifdef MISALIGN_TRAP_EN
        trap = mis;
`else
        trap = 1'b0;
`endif
        access = legal && !trap;
        eoff   = (int'(a[1:0]) / size) * size;
        emask  = 4'd0;
        ewd    = 32'd0;
        ext    = 32'd0;
        for (int b = 0; b < 4; b++) begin
            if (st && b >= eoff && b < eoff + size) emask[b] = 1'b1;
            ewd[8*b +: 8] = wd[8*(b % size) +: 8];
        end
        for (int i = 0; i < size; i++) ext[8*i +: 8] = rdat[8*(eoff + i) +: 8];
        if (!f3[2] && size < 4 && ext[8*size-1]) ext = ext | (32'hFFFF_FFFF << (8*size));
        tmo   = !st && access && (TO != 0) && (rd >= TO);
        edata = (access && !st && !tmo) ? ext : 32'd0;

        @(negedge clk);
        check("ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
        @(negedge clk);
        req_valid = 1'b0; wdata = $urandom;
        if (access) begin
            for (int k = 0; k <= gd; k++) begin
                check("mem_req",  {31'd0, mem_req}, 32'd1);
                check("ready_busy", {31'd0, req_ready}, 32'd0);
                check("mem_addr", mem_addr, {a[31:2], 2'b00});
                check("mem_we",   {31'd0, mem_we}, {31'd0, st});
                check("mem_wmask", {28'd0, mem_wmask}, {28'd0, emask});
                if (st) check("mem_wdata", mem_wdata, ewd);
                if (k == gd) mem_gnt = 1'b1;
                @(negedge clk);
                mem_gnt = 1'b0;
            end
            if (!st) begin
                for (int w = 0; w < TO + 8; w++) begin
                    check("wait_req", {30'd0, mem_req, rsp_valid}, 32'd0);
                    if (w == rd) begin mem_rvalid = 1'b1; mem_rdata = rdat; end
                    @(negedge clk);
                    mem_rvalid = 1'b0; mem_rdata = $urandom;
                    if (w == rd || w == TO - 1) break;
                end
            end
        end else begin
            check("no_mem_req", {31'd0, mem_req}, 32'd0);
        end
        check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("rsp_data",  rsp_data, edata);
        check("err",       {31'd0, err}, {31'd0, (!legal || tmo)});
        check("misalign",  {31'd0, misalign}, {31'd0, trap});
        check("ready_resp", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        check("rsp_pulse", {31'd0, rsp_valid}, 32'd0);
        check("rsp_hold",  rsp_data, edata);
        check("err_hold",  {31'd0, err}, {31'd0, (!legal || tmo)});
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; is_store = 1'b0; funct3 = 3'd0;
        addr = 32'd0; wdata = 32'd0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_outs", {26'd0, mem_req, mem_we, rsp_valid, err, misalign, 1'b0}, 32'd0);
        check("rst_bus", mem_addr | mem_wdata | rsp_data | {28'd0, mem_wmask}, 32'd0);
        rst = 1'b0;

        do_op(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 0, 0, 32'd0);
        do_op(1'b1, 3'd0, 32'h103, 32'h000000A5, 0, 0, 32'd0);
        do_op(1'b0, 3'd0, 32'h102, 32'd0, 0, 0, 32'h12C45678);
        do_op(1'b0, 3'd4, 32'h102, 32'd0, 1, 2, 32'h12C45678);
        do_op(1'b0, 3'd1, 32'h102, 32'd0, 0, 1, 32'h12C45678);
        do_op(1'b1, 3'd3, 32'h104, 32'h1, 0, 0, 32'd0);
        do_op(1'b0, 3'd6, 32'h104, 32'h1, 0, 0, 32'd0);
        do_op(1'b0, 3'd2, 32'h102, 32'd0, 0, 0, 32'h89ABCDEF);
        do_op(1'b1, 3'd1, 32'h103, 32'h0000BEEF, 0, 0, 32'd0);
        do_op(1'b0, 3'd2, 32'h300, 32'd0, 0, TO - 1, 32'h5555AAAA);

        // Response timeout, then a late rvalid and a stray gnt must be ignored.
        do_op(1'b0, 3'd2, 32'h200, 32'd0, 0, TO + 3, 32'h0);
        mem_rvalid = 1'b1; mem_gnt = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0; mem_gnt = 1'b0;
        check("late_rvalid", {30'd0, rsp_valid, mem_req}, 32'd0);
        check("late_ready", {31'd0, req_ready}, 32'd1);

        // gnt withheld three cycles, then reset mid-WAIT on a later load.
        do_op(1'b0, 3'd5, 32'h402, 32'd0, 3, 0, 32'hF00DCAFE);
        @(negedge clk);
        req_valid = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = 32'h500;
        @(negedge clk);
        req_valid = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_mid_req", {31'd0, mem_req}, 32'd0);
        check("rst_mid_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0; mem_rvalid = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
            @(negedge clk);
        end

        for (int n = 0; n < 60; n++) begin
            do_op(1'($urandom), 3'($urandom), $urandom, $urandom,
                  int'($urandom_range(0, 2)), int'($urandom_range(0, TO + 1)), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage directly downstream of the execute-stage ALU. It consumes the ALU result as the effective address of a RISC-V load or store. It drives a single-outstanding-request data-memory port with a req/gnt/rvalid handshake, generates byte-lane masks and replicated store data, and returns sign- or zero-extended load data to writeback. The pipeline stalls via req_ready_o while a transaction is in flight.

Parameters:
RSP_TIMEOUT, 255, max cycles in WAIT before a bus error; 0 disables the timeout.

Ports:
clk_i  input  1  clock
rst_i  input  1  reset, asynchronous, active-high
req_valid_i  input  1  execute stage presents a memory op
req_ready_o  output  1  LSU can accept an op (high only in IDLE)
is_store_i  input  1  1 = store, 0 = load
funct3_i  input  3  RV32I width/sign: 0 B, 1 H, 2 W, 4 BU, 5 HU
addr_i  input  32  effective address (ALU result)
wdata_i  input  32  store data (rs2)
mem_req_o  output  1  memory request valid
mem_we_o  output  1  write enable
mem_addr_o  output  32  word-aligned address, {addr[31:2],2'b00}
mem_wmask_o  output  4  byte-lane write mask
mem_wdata_o  output  32  lane-replicated store data
mem_gnt_i  input  1  memory accepted request
mem_rvalid_i  input  1  load data valid
mem_rdata_i  input  32  load data word
rsp_valid_o  output  1  one-cycle completion pulse
rsp_data_o  output  32  extended load data; 0 for stores and errors
err_o  output  1  bus error, qualified by rsp_valid_o
misalign_o  output  1  misaligned access, qualified by rsp_valid_o

Behaviour:
- Reset (async): state IDLE; req_ready_o=1; all other outputs 0. Reset mid-transaction abandons it: mem_req_o drops immediately and no response is produced.
- Handshake: on req_valid_i & req_ready_o, register is_store, funct3, addr and wdata, then go to REQ. All mem_* outputs are driven from registers.
- IDLE:
  - Illegal funct3 (load 3/6/7; store >= 3): no memory access; go to RESP with err_o=1.
  - Otherwise go to REQ.
- REQ: mem_req_o=1; addr, we, wmask and wdata held stable until mem_gnt_i. On gnt, a store goes to RESP and a load goes to WAIT.
- WAIT:
  - Counter increments every cycle.
  - mem_rvalid_i: capture and extend the data, go to RESP.
  - If RSP_TIMEOUT != 0 and the count reaches RSP_TIMEOUT with no rvalid: go to RESP with err_o=1 and rsp_data_o=0.
  - If rvalid and timeout coincide, rvalid wins.
- RESP: rsp_valid_o=1 for exactly one cycle, then IDLE. err_o, misalign_o and rsp_data_o hold until the next accept.
- Stray handshakes: mem_gnt_i outside REQ and mem_rvalid_i outside WAIT are ignored.
- Latency:
  - Store with same-cycle gnt: accept at cycle N, REQ at N+1, rsp_valid_o at N+2.
  - Load with gnt at N+1 and rvalid at N+2: rsp_valid_o at N+3.
  - No back-to-back acceptance: req_ready_o is low from N+1 through the RESP cycle.
- Lane rules, off = addr[1:0]:
  - SB: wmask = 4'b0001 << off; wdata = {4{wdata[7:0]}}.
  - SH: wmask = 4'b0011 << (2*off[1]); wdata = {2{wdata[15:0]}}.
  - SW: wmask = 4'b1111; wdata passed through.
  - Loads: mem_wmask_o = 0 and mem_we_o = 0.
- Load extract:
  - LB/LBU: byte at lane off, sign-/zero-extended.
  - LH/LHU: halfword at lane off[1], sign-/zero-extended.
  - LW: full word.
- Misaligned: H with addr[0]=1, or W with addr[1:0] != 0.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: a misaligned op skips memory (no mem_req_o) and goes IDLE -> RESP with misalign_o=1, rsp_data_o=0 and err_o=0.
- Undefined: misalign_o is tied 0, and the access proceeds with the offending low bits ignored (H uses addr[1] only; W uses the aligned word).

Test Plan:
1. SW addr 0x100, wdata 0xDEADBEEF, gnt in the first REQ cycle -> mem_addr 0x100, wmask 1111, wdata 0xDEADBEEF, we=1; rsp_valid_o 2 cycles after accept, rsp_data 0.
2. SB addr 0x103, wdata 0x000000A5 -> mem_addr 0x100, wmask 1000, wdata 0xA5A5A5A5.
3. Loads at addr 0x102 with rdata 0x12C45678:
   - LB -> 0xFFFFFFC4
   - LBU -> 0x000000C4
   - LH -> 0x000012C4
4. gnt withheld 3 cycles, then reset asserted mid-WAIT on a later load -> mem_req_o, address and mask stable for all 3 REQ cycles with req_ready_o=0; after reset, mem_req_o=0, req_ready_o=1 and no rsp_valid_o.
5. RSP_TIMEOUT=4, load granted but rvalid never arrives -> rsp_valid_o with err_o=1 and rsp_data 0 after 4 WAIT cycles; a late rvalid is ignored.
6. LW addr 0x102 -> with macro: misalign_o=1 and no mem_req_o; without macro: mem_addr 0x100 with a normal word return.
